// File: rtl/spi_rx_deser.sv
// LSB-first serial-to-parallel receiver with a DEPTH-entry word FIFO and a
// valid/ready output port. Overrun and framing errors are reported as sticky flags.
module spi_rx_deser #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_bit,
  input  logic                      rx_vld,
  input  logic                      rx_sync,
  input  logic [5:0]                data_len,
  output logic [31:0]               m_data,
  output logic [5:0]                m_len,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overrun,
  output logic                      frame_err,
  input  logic                      err_clr
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned DW = 32;
  localparam int unsigned EW = DW + 6;

  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [5:0]    cur_len_q, cur_len_d;
  logic [DW-1:0] asm_q, asm_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [5:0]    m_len_q, m_len_d;
  logic          m_valid_q, m_valid_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;

  logic [5:0]    len_clamp;
  logic          word_start;
  logic [5:0]    eff_len;
  logic [5:0]    pos;
  logic [DW-1:0] asm_bit;
  logic          word_done;
  logic          frame_evt;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          drop;
  logic [EW-1:0] head;

  // Word assembly: rx_sync or an idle counter restarts the word and re-latches the length.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    cur_len_d = cur_len_q;
    asm_d     = asm_q;
    if (data_len < 6'd8)       len_clamp = 6'd8;
    else if (data_len > 6'd32) len_clamp = 6'd32;
    else                       len_clamp = data_len;
    word_start = rx_sync || (bit_cnt_q == 6'd0);
    eff_len    = word_start ? len_clamp : cur_len_q;
    pos        = rx_sync ? 6'd0 : bit_cnt_q;
    asm_bit    = (word_start ? '0 : asm_q) | (DW'(rx_bit) << pos[4:0]);
    word_done  = rx_vld && (pos == (eff_len - 6'd1));
    frame_evt  = rx_vld && rx_sync && (bit_cnt_q != 6'd0);
    if (rx_vld) begin
      cur_len_d = eff_len;
      if (word_done) begin
        bit_cnt_d = 6'd0;
        asm_d     = '0;
      end else begin
        bit_cnt_d = pos + 6'd1;
        asm_d     = asm_bit;
      end
    end
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when a pop happens on the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop      = m_valid_q && m_ready;
    full     = (count_q == LW'(DEPTH));
    push_ok  = word_done && (!full || pop);
    drop     = word_done && full && !pop;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {eff_len, asm_bit};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + LW'(push_ok) - LW'(pop);
  end

  // Registered head-of-queue view; reads zero while the FIFO is empty.
  always_comb begin
    head      = mem_d[rd_ptr_d];
    m_valid_d = (count_d != '0);
    m_data_d  = '0;
    m_len_d   = '0;
    if (m_valid_d) begin
      m_data_d = head[DW-1:0];
      m_len_d  = head[EW-1:DW];
    end
    overrun_d   = drop || (overrun_q && !err_clr);
    frame_err_d = frame_evt || (frame_err_q && !err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      cur_len_q   <= 6'd8;
      asm_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      m_data_q    <= '0;
      m_len_q     <= '0;
      m_valid_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      cur_len_q   <= cur_len_d;
      asm_q       <= asm_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      m_data_q    <= m_data_d;
      m_len_q     <= m_len_d;
      m_valid_q   <= m_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

  assign m_data    = m_data_q;
  assign m_len     = m_len_q;
  assign m_valid   = m_valid_q;
  assign level     = count_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_rx_deser.sv
// Randomised bench for spi_rx_deser: a word-level driver feeds a queue-based
// reference FIFO; a negedge monitor compares the DUT outputs against that queue.
module tb_spi_rx_deser;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_bit = 1'b0, rx_vld = 1'b0, rx_sync = 1'b0;
  logic [5:0]  data_len = 6'd8;
  logic [31:0] m_data;
  logic [5:0]  m_len;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [2:0]  level;
  logic        overrun, frame_err;
  logic        err_clr = 1'b0;

  spi_rx_deser #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_bit(rx_bit), .rx_vld(rx_vld), .rx_sync(rx_sync),
    .data_len(data_len), .m_data(m_data), .m_len(m_len), .m_valid(m_valid),
    .m_ready(m_ready), .level(level), .overrun(overrun), .frame_err(frame_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Driver-side annotations describing what the current accepted bit means.
  logic        word_end = 1'b0;
  logic        fe_evt = 1'b0;
  logic        partial = 1'b0;
  logic [31:0] exp_data = '0;
  logic [5:0]  exp_len = '0;
  int          rdy_mode = 0;

  logic [37:0] exp_q[$];
  logic        ovr_m = 1'b0, fe_m = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference FIFO: pop happens before push, so a full FIFO with a pop accepts the word.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      ovr_m = 1'b0;
      fe_m  = 1'b0;
    end else begin
      bit popm, was_full, drop_m;
      popm     = (exp_q.size() > 0) && m_ready;
      was_full = (exp_q.size() == DEPTH);
      drop_m   = 1'b0;
      if (popm) void'(exp_q.pop_front());
      if (rx_vld && word_end) begin
        if (!was_full || popm) exp_q.push_back({exp_len, exp_data});
        else drop_m = 1'b1;
      end
      ovr_m = drop_m || (ovr_m && !err_clr);
      fe_m  = (rx_vld && fe_evt) || (fe_m && !err_clr);
    end
  end

  always @(negedge clk) begin
    chk("m_valid", 32'(m_valid), 32'(exp_q.size() > 0));
    chk("level", 32'(level), 32'(exp_q.size()));
    chk("overrun", 32'(overrun), 32'(ovr_m));
    chk("frame_err", 32'(frame_err), 32'(fe_m));
    if (exp_q.size() > 0) begin
      chk("m_data", m_data, exp_q[0][31:0]);
      chk("m_len", 32'(m_len), 32'(exp_q[0][37:32]));
    end else if (!rst_n) begin
      chk("rst_m_data", m_data, 32'd0);
      chk("rst_m_len", 32'(m_len), 32'd0);
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) m_ready = 1'b0;
      else if (rdy_mode == 1) m_ready = 1'b1;
      else if (rdy_mode == 2) m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] v, input int lf, input bit sy,
                           input int gap, input bit mid_chg);
    int eff;
    logic [63:0] msk;
    eff = (lf < 8) ? 8 : ((lf > 32) ? 32 : lf);
    msk = (64'd1 << eff) - 64'd1;
    for (int k = 0; k < eff; k++) begin
      rx_vld   = 1'b1;
      rx_bit   = v[k];
      rx_sync  = (k == 0) && sy;
      fe_evt   = (k == 0) && sy && partial;
      if (k == 0) data_len = 6'(lf);
      else if (mid_chg) data_len = 6'($urandom);
      word_end = (k == eff - 1);
      exp_data = v & msk[31:0];
      exp_len  = 6'(eff);
      if (rdy_mode == 3) m_ready = (k == eff - 1);
      tick();
      rx_vld = 1'b0; rx_sync = 1'b0; fe_evt = 1'b0; word_end = 1'b0;
      partial = (k != eff - 1);
      repeat (gap) tick();
    end
  endtask

  task automatic send_partial(input int n);
    for (int k = 0; k < n; k++) begin
      rx_vld   = 1'b1;
      rx_bit   = 1'($urandom_range(0, 1));
      rx_sync  = (k == 0);
      fe_evt   = (k == 0) && partial;
      data_len = 6'd8;
      tick();
      rx_vld = 1'b0; rx_sync = 1'b0; fe_evt = 1'b0;
      partial = 1'b1;
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic drain();
    int n;
    rdy_mode = 1;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin tick(); n++; end
    if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Basic byte, 32-bit clamp and short-length clamp
    rdy_mode = 1;
    send_word(32'hA5, 8, 1'b1, 0, 1'b0);
    repeat (3) tick();
    send_word(32'hDEADBEEF, 40, 1'b1, 0, 1'b0);
    send_word(32'h0000_00C3, 3, 1'b0, 0, 1'b0);
    repeat (3) tick();

    // Overrun: five words into a four-entry FIFO with no consumer
    rdy_mode = 0;
    for (int i = 1; i <= 5; i++) send_word(32'(i), 8, 1'b0, 0, 1'b0);
    repeat (3) tick();
    drain();
    pulse_clr();

    // Framing error then a clean resynchronised word
    rdy_mode = 1;
    send_partial(5);
    send_word(32'h3C, 8, 1'b1, 0, 1'b0);
    repeat (2) tick();
    pulse_clr();

    // Sparse valid with a mid-word length change
    send_word(32'h1234, 16, 1'b0, 2, 1'b1);
    repeat (3) tick();

    // Full FIFO with a pop on the same cycle as the fifth push
    rdy_mode = 0;
    tick();
    for (int i = 0; i < 4; i++) send_word($urandom, 8, 1'b0, 0, 1'b0);
    rdy_mode = 3;
    send_word(32'h55, 8, 1'b0, 0, 1'b0);
    rdy_mode = 0;
    repeat (2) tick();

    // Async reset in the middle of a word
    send_partial(3);
    #3 rst_n = 1'b0;
    partial = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      rdy_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) send_partial($urandom_range(1, 7));
      send_word($urandom, $urandom_range(0, 40), partial | 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) pulse_clr();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
